// File: rtl/reset_sequencer.sv
// reset_sequencer: releases STAGES reset outputs one by one after a minimum hold time and a
// filtered PLL lock. A PLL lock loss or a software request restarts the whole sequence.
//
// Ports:
//   i_clk        - single clock
//   i_srst       - synchronous active-high reset
//   i_pll_locked - PLL lock status, synchronous to i_clk
//   i_sw_rst_req - single-cycle software reset request
//   o_rst        - per-stage resets, polarity set by OUT_RST_ACTIVE; bit k releases before bit k+1
//   o_ready      - high only when every stage is released
//   o_state      - debug state: 0 ASSERT, 1 WAIT_LOCK, 2 RELEASE, 3 DONE
module reset_sequencer #(
  parameter int unsigned STAGES         = 3,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned LOCK_FILTER    = 4,
  parameter int unsigned GAP_CYCLES     = 8,
  parameter string       OUT_RST_ACTIVE = "HIGH"
) (
  input  logic              i_clk,
  input  logic              i_srst,
  input  logic              i_pll_locked,
  input  logic              i_sw_rst_req,
  output logic [STAGES-1:0] o_rst,
  output logic              o_ready,
  output logic [1:0]        o_state
);

  localparam int unsigned MaxHl  = (HOLD_CYCLES > LOCK_FILTER) ? HOLD_CYCLES : LOCK_FILTER;
  localparam int unsigned MaxCyc = (MaxHl > GAP_CYCLES) ? MaxHl : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCyc) + 1;
  localparam int unsigned IdxW   = (STAGES > 1) ? $clog2(STAGES) : 1;

  // Level driven onto o_rst while a stage is held in reset.
  localparam logic RstOn = (OUT_RST_ACTIVE == "LOW") ? 1'b0 : 1'b1;

  localparam logic [CntW-1:0] HoldLast  = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] LockLast  = CntW'(LOCK_FILTER - 1);
  localparam logic [CntW-1:0] GapLast   = CntW'(GAP_CYCLES - 1);
  localparam logic [IdxW-1:0] StageLast = IdxW'(STAGES - 1);

  // Elaboration-time parameter checks.
  if (STAGES == 0 || STAGES > 8) begin : g_err_stages
    $error("reset_sequencer: STAGES must be in 1..8");
  end
  if (HOLD_CYCLES == 0) begin : g_err_hold
    $error("reset_sequencer: HOLD_CYCLES must be >= 1");
  end
  if (LOCK_FILTER == 0) begin : g_err_lock
    $error("reset_sequencer: LOCK_FILTER must be >= 1");
  end
  if (GAP_CYCLES == 0) begin : g_err_gap
    $error("reset_sequencer: GAP_CYCLES must be >= 1");
  end
  if (OUT_RST_ACTIVE != "HIGH" && OUT_RST_ACTIVE != "LOW") begin : g_err_pol
    $error("reset_sequencer: OUT_RST_ACTIVE must be \"HIGH\" or \"LOW\"");
  end

  typedef enum logic [1:0] {
    StAssert   = 2'd0,
    StWaitLock = 2'd1,
    StRelease  = 2'd2,
    StDone     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   stage_q, stage_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;
  logic              abort;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    rst_d   = rst_q;
    ready_d = ready_q;

    // Lock loss only matters once release has begun; the software request aborts anywhere,
    // including ASSERT, where it restarts the hold count.
    abort = i_sw_rst_req ||
            (!i_pll_locked && (state_q == StRelease || state_q == StDone));

    if (abort) begin
      state_d = StAssert;
      cnt_d   = '0;
      stage_d = '0;
      rst_d   = {STAGES{RstOn}};
      ready_d = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == HoldLast) begin
            state_d = StWaitLock;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StWaitLock: begin
          if (!i_pll_locked) begin
            cnt_d = '0;
          end else if (cnt_q == LockLast) begin
            state_d = StRelease;
            cnt_d   = '0;
            stage_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StRelease: begin
          if (cnt_q == GapLast) begin
            cnt_d = '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
              if (IdxW'(k) == stage_q) rst_d[k] = ~RstOn;
            end
            if (stage_q == StageLast) begin
              state_d = StDone;
              ready_d = 1'b1;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          // Hold until an abort.
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q <= StAssert;
      cnt_q   <= '0;
      stage_q <= '0;
      rst_q   <= {STAGES{RstOn}};
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int H = 16;
  localparam int L = 4;
  localparam int G = 8;
  localparam int S = 3;
  localparam int RsNom = H + L - 1;  // edge at which WAIT_LOCK exits with lock held high

  typedef struct {
    string      tag;
    logic [2:0] rst;
    logic       ready;
    logic [1:0] st;
  } exp_t;

  logic       clk;
  logic       srst, lock, sw;
  logic [2:0] rst_a;
  logic       ready_a;
  logic [1:0] st_a;

  logic       srst_b, lock_b, sw_b;
  logic [0:0] rst_b;
  logic       ready_b;
  logic [1:0] st_b;

  exp_t sb_a[$];
  exp_t sb_b[$];

  int n_vec = 0;
  int n_err = 0;

  reset_sequencer u_dut (
    .i_clk        (clk),
    .i_srst       (srst),
    .i_pll_locked (lock),
    .i_sw_rst_req (sw),
    .o_rst        (rst_a),
    .o_ready      (ready_a),
    .o_state      (st_a)
  );

  reset_sequencer #(
    .STAGES         (1),
    .HOLD_CYCLES    (1),
    .LOCK_FILTER    (1),
    .GAP_CYCLES     (1),
    .OUT_RST_ACTIVE ("LOW")
  ) u_dut_b (
    .i_clk        (clk),
    .i_srst       (srst_b),
    .i_pll_locked (lock_b),
    .i_sw_rst_req (sw_b),
    .o_rst        (rst_b),
    .o_ready      (ready_b),
    .o_state      (st_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs after edge n of a sequence whose WAIT_LOCK exit happens at edge rs.
  function automatic exp_t seq_exp(input int n, input int rs);
    exp_t e;
    e.tag = "seq";
    for (int k = 0; k < S; k++) e.rst[k] = (n < rs + (k + 1) * G);
    e.ready = (n >= rs + S * G);
    if (n < H - 1)           e.st = 2'd0;
    else if (n < rs)         e.st = 2'd1;
    else if (n < rs + S * G) e.st = 2'd2;
    else                     e.st = 2'd3;
    return e;
  endfunction

  function automatic exp_t rst_exp();
    exp_t e;
    e.tag   = "rst";
    e.rst   = 3'b111;
    e.ready = 1'b0;
    e.st    = 2'd0;
    return e;
  endfunction

  // Second instance: active-low, one stage, H=L=G=1. n<0 means still in reset.
  function automatic exp_t b_exp(input int n);
    exp_t e;
    e.tag   = "b";
    e.rst   = 3'b000;
    e.ready = 1'b0;
    e.st    = 2'd0;
    if (n == 0) e.st = 2'd1;
    else if (n == 1) e.st = 2'd2;
    else if (n >= 2) begin
      e.st    = 2'd3;
      e.rst   = 3'b001;
      e.ready = 1'b1;
    end
    return e;
  endfunction

  task automatic drive(input logic s, input logic l, input logic r, input string tag,
                       input exp_t e);
    exp_t x;
    @(negedge clk);
    srst = s;
    lock = l;
    sw   = r;
    x     = e;
    x.tag = tag;
    sb_a.push_back(x);
  endtask

  task automatic run_seq(input int from, input int to, input int rs, input string tag);
    for (int n = from; n <= to; n++) drive(1'b0, 1'b1, 1'b0, $sformatf("%s@E%0d", tag, n),
                                           seq_exp(n, rs));
  endtask

  // Monitor: compare each edge's outputs against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb_a.size() > 0) begin
        e = sb_a.pop_front();
        check_eq({e.tag, ".rst"},   {5'b0, rst_a},   {5'b0, e.rst});
        check_eq({e.tag, ".ready"}, {7'b0, ready_a}, {7'b0, e.ready});
        check_eq({e.tag, ".state"}, {6'b0, st_a},    {6'b0, e.st});
      end
      if (sb_b.size() > 0) begin
        e = sb_b.pop_front();
        check_eq({e.tag, ".rst"},   {7'b0, rst_b},   {7'b0, e.rst[0]});
        check_eq({e.tag, ".ready"}, {7'b0, ready_b}, {7'b0, e.ready});
        check_eq({e.tag, ".state"}, {6'b0, st_b},    {6'b0, e.st});
      end
    end
  end

  initial begin
    exp_t eb;
    srst   = 1'b1;
    lock   = 1'b1;
    sw     = 1'b0;
    srst_b = 1'b1;
    lock_b = 1'b1;
    sw_b   = 1'b0;

    // Reset values on both instances; the small instance runs its whole sequence here.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      srst   = 1'b1;
      srst_b = (i < 2);
      sb_a.push_back(rst_exp());
      eb     = b_exp(i - 2);
      eb.tag = $sformatf("lowpol@%0d", i);
      sb_b.push_back(eb);
    end

    // Nominal sequence into DONE.
    run_seq(0, 47, RsNom, "nominal");

    // Software request in DONE, then a second one at ASSERT counter 10.
    drive(1'b0, 1'b1, 1'b1, "sw_in_done", rst_exp());
    run_seq(0, 9, RsNom, "resq");
    drive(1'b0, 1'b1, 1'b1, "sw_in_assert", rst_exp());
    run_seq(0, 45, RsNom, "rehold");

    // Lock low at E18 inside WAIT_LOCK: filter restarts, release start moves to E22.
    drive(1'b1, 1'b1, 1'b0, "srst2", rst_exp());
    run_seq(0, 17, 22, "glitch");
    drive(1'b0, 1'b0, 1'b0, "lock_low_e18", seq_exp(18, 22));
    run_seq(19, 47, 22, "glitch");

    // Lock low at the last filter count (E19) must not release.
    drive(1'b1, 1'b1, 1'b0, "srst3", rst_exp());
    run_seq(0, 18, 23, "lastcnt");
    drive(1'b0, 1'b0, 1'b0, "lock_low_e19", seq_exp(19, 23));
    run_seq(20, 32, 23, "lastcnt");

    // Lock drop at E30 in RELEASE, then a clean re-sequence.
    drive(1'b1, 1'b1, 1'b0, "srst4", rst_exp());
    run_seq(0, 29, RsNom, "drop");
    drive(1'b0, 1'b0, 1'b0, "lock_drop_e30", rst_exp());
    run_seq(0, 45, RsNom, "afterdrop");

    // Lock drop in DONE; lock low during ASSERT is ignored.
    drive(1'b0, 1'b0, 1'b0, "lock_drop_done", rst_exp());
    drive(1'b0, 1'b0, 1'b0, "lock_low_assert", seq_exp(0, RsNom));
    run_seq(1, 21, RsNom, "ign");
    // Request together with a lock drop in RELEASE: a single abort.
    drive(1'b0, 1'b0, 1'b1, "sw_and_drop", rst_exp());

    // i_srst with a request mid-RELEASE, held for a few cycles.
    run_seq(0, 29, RsNom, "pre_srst");
    drive(1'b1, 1'b1, 1'b1, "srst_sw", rst_exp());
    drive(1'b1, 1'b0, 1'b0, "srst_hold0", rst_exp());
    drive(1'b1, 1'b1, 1'b1, "srst_hold1", rst_exp());
    drive(1'b1, 1'b1, 1'b0, "srst_hold2", rst_exp());
    run_seq(0, 28, RsNom, "post_srst");

    @(negedge clk);
    @(negedge clk);
    check_eq("sb_a_drained", 8'(sb_a.size()), 8'd0);
    check_eq("sb_b_drained", 8'(sb_b.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Generates ordered, per-domain reset releases from one already-synchronized reset. Sits downstream of the reset synchronizer in the clock/reset subsystem. Holds every downstream reset asserted for a minimum time, waits for a stable PLL lock, then releases `STAGES` reset outputs one by one with a fixed gap. Re-enters the sequence on PLL lock loss or on a software reset request.

## Interface
- `STAGES`, 3, number of sequenced reset outputs; legal range 1..8.
- `HOLD_CYCLES`, 16, minimum cycles all outputs stay asserted after (re)entry to ASSERT; ≥1.
- `LOCK_FILTER`, 4, consecutive cycles `i_pll_locked` must be high before release starts; ≥1.
- `GAP_CYCLES`, 8, cycles between successive stage releases, also applied before stage 0; ≥1.
- `OUT_RST_ACTIVE`, "HIGH", polarity of `o_rst`: "HIGH" or "LOW".
- `i_clk` input 1 — the single clock.
- `i_srst` input 1 — synchronous, active-high reset. Sampled only on rising `i_clk`.
- `i_pll_locked` input 1 — PLL lock status, synchronous to `i_clk`.
- `i_sw_rst_req` input 1 — single-cycle software reset request.
- `o_rst` output STAGES — per-stage resets. Bit k releases before bit k+1.
- `o_ready` output 1 — high only when all stages are released.
- `o_state` output 2 — debug encoding: 0 ASSERT, 1 WAIT_LOCK, 2 RELEASE, 3 DONE.

## Operation
- All outputs are registered.
- Reset (`i_srst`=1) gives: state ASSERT, counter 0, stage index 0, every `o_rst` bit asserted at the `OUT_RST_ACTIVE` polarity, `o_ready`=0, `o_state`=0.
- ASSERT state:
  - Counter increments each cycle.
  - At counter = HOLD_CYCLES-1: go to WAIT_LOCK and clear the counter.
  - `i_pll_locked` is ignored in this state.
- WAIT_LOCK state:
  - Counter increments while locked, and is cleared on any low sample.
  - When the counter reaches LOCK_FILTER-1 while locked: go to RELEASE, clear the counter, stage index = 0.
- RELEASE state:
  - Counter increments each cycle.
  - At counter = GAP_CYCLES-1: deassert `o_rst[stage]`, clear the counter, increment the stage index.
  - When the stage released is STAGES-1: go to DONE and set `o_ready`=1 on the same edge.
- DONE state: holds all outputs until an abort event.
- Abort events, in priority order:
  1. `i_srst`.
  2. `i_pll_locked`=0 while in RELEASE or DONE.
  3. `i_sw_rst_req`=1 in any state.
- Abort action on the next edge: state ASSERT, counter 0, stage index 0, all `o_rst` asserted, `o_ready`=0.
- `i_sw_rst_req` during ASSERT restarts the hold count. A request in the cycle that would otherwise exit ASSERT keeps the block in ASSERT.
- Released stages stay released until an abort. Each bit of `o_rst` changes only at release or abort; there are no glitches or partial re-asserts.
- Counter width is clog2(max(HOLD_CYCLES, LOCK_FILTER, GAP_CYCLES)) + 1. Wrap-around is impossible by construction.
- Illegal parameter values stop elaboration via a generate-time error.

## Timing
- Edge E0 is the first rising edge at which `i_srst` is sampled 0. `i_pll_locked` is held high.
  - ASSERT covers edges E0 to E(H-1).
  - WAIT_LOCK covers edges E(H) to E(H+L-1).
  - `o_rst[k]` deasserts at edge E(H+L+(k+1)·G-1).
  - `o_ready` rises on the same edge as `o_rst[STAGES-1]`.
  - Here H = HOLD_CYCLES, L = LOCK_FILTER, G = GAP_CYCLES.
- Abort latency is one edge: the event is sampled at edge N and outputs are asserted after edge N.
- `i_sw_rst_req` coinciding with a lock drop or `i_srst`: same result, a single abort.
- A lock low-sample in WAIT_LOCK at counter = L-1 does not release. The count restarts.

## Test plan
1. Defaults, lock high, `i_srst` dropped at E0 → `o_rst[0]` low after E27, `o_rst[1]` after E35, `o_rst[2]` and `o_ready` after E43. `o_state` goes 0→1 at E15, 1→2 at E19, 2→3 at E43.
2. Lock low for one cycle at E18 (inside WAIT_LOCK) → the filter restarts. Every release time shifts to E(t+L) relative to the resumed high samples, with no early release.
3. Lock drop at E30 (stage 0 released, in RELEASE) → all `o_rst` asserted and `o_ready`=0 after E30. With lock restored, ASSERT lasts 16 cycles again and the full sequence repeats.
4. `i_sw_rst_req` pulse in DONE → full re-sequence. A second pulse at ASSERT counter = 10 restarts the hold, so exit to WAIT_LOCK comes 16 cycles after that pulse.
5. `i_srst`=1 mid-RELEASE together with `i_sw_rst_req` → all outputs return to reset values after one edge, and they hold while `i_srst`=1.
6. `OUT_RST_ACTIVE`="LOW", `STAGES`=1, H=L=G=1 → `o_rst` low during reset and goes high with `o_ready` at E2.
